// File: rtl/byte_ram_4x8.sv
// byte_ram_4x8 -- 4-entry x 8-bit flip-flop register-file RAM.
//
// Each word is split into two nibble banks (low = bits 3:0, high = bits 7:4)
// that share one address. A single mode bit picks the operation: read=0
// writes i into mem[select] through a one-hot decoder, read=1 loads the
// addressed word into the output register o through a 4:1 mux.
//
// Ports:
//   clk        in   rising-edge clock
//   clear      in   synchronous active-high reset: zeroes storage and o
//   i          in   write data [DATA_W]
//   select     in   word address [ADDR_W], shared by read and write
//   read       in   mode, 0 = write, 1 = read
//   o          out  registered read data [DATA_W], held during writes
//   parity_err out  BYTE_RAM_PARITY_EN only: registered parity check of
//                   the word last read
//
// Optional feature macro: BYTE_RAM_PARITY_EN. When defined each word carries
// an even-parity bit written with the data and checked on read.

// One nibble bank: DEPTH words of W bits, written through a one-hot enable
// and read combinationally at select.
module byte_ram_bank #(
  parameter int W      = 4,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DEPTH-1:0]  we,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] select,
  output logic [W-1:0]      rdata
);

  logic [DEPTH-1:0][W-1:0] mem;

  genvar w;
  generate
    for (w = 0; w < DEPTH; w++) begin : g_word
      always_ff @(posedge clk) begin
        if (clear)      mem[w] <= '0;
        else if (we[w]) mem[w] <= wdata;
      end
    end
  endgenerate

  assign rdata = mem[select];

endmodule

module byte_ram_4x8 #(
  parameter int DATA_W = 8,   // must be even: split into two nibble banks
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] i,
  input  logic [ADDR_W-1:0] select,
  input  logic              read,
`ifdef BYTE_RAM_PARITY_EN
  output logic [DATA_W-1:0] o,
  output logic              parity_err
`else
  output logic [DATA_W-1:0] o
`endif
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int NUM_BANKS = 2;
  localparam int NIB_W     = DATA_W / NUM_BANKS;

  // Write decoder: exactly one word enabled, and only in write mode.
  logic [DEPTH-1:0] we;
  always_comb begin
    we = '0;
    if (!read) we[select] = 1'b1;
  end

  logic [NUM_BANKS-1:0][NIB_W-1:0] bank_rd;
  logic [DATA_W-1:0]               rd_word;

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      byte_ram_bank #(
        .W      (NIB_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_bank (
        .clk    (clk),
        .clear  (clear),
        .we     (we),
        .wdata  (i[b*NIB_W +: NIB_W]),
        .select (select),
        .rdata  (bank_rd[b])
      );
    end
  endgenerate

  // Bank 0 lands in the low nibble, bank 1 in the high nibble.
  assign rd_word = bank_rd;

  // Output register: only a read cycle loads it, so o holds across writes.
  always_ff @(posedge clk) begin
    if (clear)     o <= '0;
    else if (read) o <= rd_word;
  end

`ifdef BYTE_RAM_PARITY_EN
  // Parity bits share the data decoder. A cleared word is all zeros with
  // parity 0, which is already a consistent even-parity word.
  logic [DEPTH-1:0] par_mem;

  genvar p;
  generate
    for (p = 0; p < DEPTH; p++) begin : g_par
      always_ff @(posedge clk) begin
        if (clear)      par_mem[p] <= 1'b0;
        else if (we[p]) par_mem[p] <= ^i;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clear)     parity_err <= 1'b0;
    else if (read) parity_err <= (^rd_word) ^ par_mem[select];
  end
`endif

endmodule

// File: tb/tb_byte_ram_4x8.sv
module tb_byte_ram_4x8;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] i;
  logic [1:0] select;
  logic       read;
  logic [7:0] o;
`ifdef BYTE_RAM_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state, updated as each stimulus cycle is issued.
  logic [7:0] m_mem [4];
  logic [7:0] m_o;
  logic       m_par [4];
  logic       m_perr;

  // Scoreboard: expected post-edge outputs, pushed at drive time.
  logic [7:0] exp_o_q [$];
  logic       exp_p_q [$];

  always #5 clk = ~clk;

  byte_ram_4x8 dut (
    .clk        (clk),
    .clear      (clear),
    .i          (i),
    .select     (select),
    .read       (read),
`ifdef BYTE_RAM_PARITY_EN
    .parity_err (parity_err),
`endif
    .o          (o)
  );

  task automatic step(input logic clr, input logic rd, input logic [1:0] sel,
                      input logic [7:0] din, input string tag);
    logic [7:0] eo;
    logic       ep;
    clear  = clr;
    read   = rd;
    select = sel;
    i      = din;
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        m_mem[k] = 8'h00;
        m_par[k] = 1'b0;
      end
      m_o    = 8'h00;
      m_perr = 1'b0;
    end else if (rd) begin
      m_o    = m_mem[sel];
      m_perr = (^m_mem[sel]) ^ m_par[sel];
    end else begin
      m_mem[sel] = din;
      m_par[sel] = ^din;
    end
    exp_o_q.push_back(m_o);
    exp_p_q.push_back(m_perr);
    @(posedge clk);
    #1;
    eo = exp_o_q.pop_front();
    ep = exp_p_q.pop_front();
    checks++;
    assert (o === eo) else begin
      errors++;
      $error("FAIL %s: o=%h expected %h", tag, o, eo);
    end
`ifdef BYTE_RAM_PARITY_EN
    checks++;
    assert (parity_err === ep) else begin
      errors++;
      $error("FAIL %s: parity_err=%b expected %b", tag, parity_err, ep);
    end
`else
    if (ep !== 1'b0) $display("note: model parity nonzero in %s", tag);
`endif
  endtask

  initial begin
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h44; pat[3] = 8'h88;
    clear = 1'b1; read = 1'b0; select = '0; i = '0;
    for (int k = 0; k < 4; k++) begin m_mem[k] = 'x; m_par[k] = 1'bx; end
    m_o = 'x; m_perr = 1'bx;

    // Reset, then every address reads zero.
    step(1'b1, 1'b0, 2'd0, 8'h00, "reset");
    for (int a = 0; a < 4; a++) step(1'b0, 1'b1, a[1:0], 8'h00, "rd_after_reset");

    // Fill all addresses (o must hold 0 across writes), then read back.
    for (int a = 0; a < 4; a++) step(1'b0, 1'b0, a[1:0], pat[a], "wr_fill");
    for (int a = 0; a < 4; a++) step(1'b0, 1'b1, a[1:0], 8'h00, "rd_fill");

    // Write isolation.
    step(1'b0, 1'b0, 2'd2, 8'hA5, "wr_iso");
    step(1'b0, 1'b1, 2'd0, 8'h00, "rd_iso0");
    step(1'b0, 1'b1, 2'd1, 8'h00, "rd_iso1");
    step(1'b0, 1'b1, 2'd3, 8'h00, "rd_iso3");
    step(1'b0, 1'b1, 2'd2, 8'h00, "rd_iso2");

    // Hold during write, then back-to-back write/read of same address.
    step(1'b0, 1'b1, 2'd1, 8'h00, "rd_hold_pre");
    step(1'b0, 1'b0, 2'd1, 8'hFF, "wr_hold");
    step(1'b0, 1'b0, 2'd0, 8'h5A, "wr_hold2");
    step(1'b0, 1'b1, 2'd1, 8'h00, "rd_hold_post");
    step(1'b0, 1'b1, 2'd0, 8'h00, "rd_b2b");

    // Nibble independence: distinct high/low nibbles per address.
    step(1'b0, 1'b0, 2'd3, 8'h3C, "wr_nib");
    step(1'b0, 1'b1, 2'd3, 8'h00, "rd_nib");

    // Clear with a pending write: no write, everything zero.
    step(1'b0, 1'b1, 2'd2, 8'h00, "rd_pre_clr");
    step(1'b1, 1'b0, 2'd3, 8'h77, "clr_wr");
    for (int a = 3; a >= 0; a--) step(1'b0, 1'b1, a[1:0], 8'h00, "rd_after_clr");

    // Random mix of reads and writes against the model.
    for (int n = 0; n < 40; n++)
      step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), "rand");

`ifdef BYTE_RAM_PARITY_EN
    step(1'b0, 1'b0, 2'd0, 8'h07, "par_wr");
    step(1'b0, 1'b1, 2'd0, 8'h00, "par_rd_ok");
    force dut.par_mem = ~dut.par_mem;
    for (int k = 0; k < 4; k++) m_par[k] = ~m_par[k];
    step(1'b0, 1'b1, 2'd0, 8'h00, "par_rd_bad");
    step(1'b0, 1'b0, 2'd1, 8'h00, "par_hold");
    release dut.par_mem;
    step(1'b1, 1'b0, 2'd0, 8'h00, "par_clr");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_ram_4x8.md
Name: byte_ram_4x8

Overview:
- 4-entry x 8-bit register-file RAM built from flip-flops.
- Each byte is stored as two nibble banks: low bank holds bits 3:0 and high bank holds bits 7:4. Both banks share the same address.
- A single `read` control selects the mode. Low means write: decoder-enabled storage. High means read: mux-enabled output.
- Used as a small scratch memory; one port, no handshake.

Parameters:
- DATA_W, 8, word width; must be even, split into two DATA_W/2 nibble banks.
- ADDR_W, 2, address width; depth = 2**ADDR_W = 4 words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset; clears all storage and output.
- i  input  DATA_W  write data.
- select  input  ADDR_W  word address, used for both write and read.
- read  input  1  mode: 0 = write, 1 = read.
- o  output  DATA_W  registered read data.
- parity_err  output  1  present only with PARITY_EN (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset `clear` is synchronous and active-high.
- Reset:
  - On a rising clk edge with clear=1, all 4 words become 0x00 and o becomes 0x00.
  - clear has priority over read and write in the same cycle; no write occurs on that edge.
- Write (read=0, clear=0):
  - At the rising edge, mem[select] <= i. Both nibble banks of that word are written together.
  - All other words are unchanged.
  - o holds its previous value; it is not updated during write cycles.
- Read (read=1, clear=0):
  - At the rising edge, o <= mem[select].
  - Latency is 1 cycle: o reflects the address sampled on the edge where read=1.
  - No memory word changes.
- Write enables come from a 2-to-4 decoder of select, gated by read=0. Exactly one word is enabled per write cycle.
- Read path is a 4:1 mux per bit, gated by read=1, feeding the o register.
- Back-to-back:
  - A write to address A followed by a read of A on the next edge returns the new data.
  - There is no same-cycle read/write, since the modes are exclusive.
- Address changes between cycles have no side effects; select is sampled only at the clock edge.
- Power-up before the first clear: contents are unspecified. Benches must assert clear before any access.
- X on read while clear=0 is an illegal stimulus; behaviour is undefined.
- The mem array holds no reset-independent state other than what is described above.

Optional Feature:
- Macro: BYTE_RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed as the XOR of i, and written with the data.
  - On a read, parity_err is registered alongside o. It is 1 if the XOR of the stored data plus the stored parity bit is 1.
  - parity_err resets to 0 and holds its value during write cycles.
  - Clear initialises the parity bits to 0, which is consistent with zero data.
- Not defined:
  - No parity storage and no parity_err port.
  - All other behaviour is identical.

Test Plan:
- Reset: clear=1 for 1 edge, then read=1 with select=0..3 -> o=0x00 for every address, 1 cycle after each select.
- Write/read all addresses:
  - Write: read=0 with select=0/1/2/3 and i=0x11/0x22/0x44/0x88.
  - Then read: read=1 with select=0,1,2,3 -> o=0x11, 0x22, 0x44, 0x88 respectively.
- Write isolation: write 0xA5 to select=2, then read addresses 0,1,3 -> their prior values unchanged, and address 2 returns 0xA5.
- Hold during write: read addr1 -> o=0x22; then write 0xFF to addr1 -> o stays 0x22 until the next read cycle, which gives 0xFF.
- Reset mid-operation: after writes, clear=1 together with read=0, select=3, i=0x77 -> no write occurs, all words are 0x00, and o=0x00 on the next edge.
- BYTE_RAM_PARITY_EN: write 0x07 then read -> parity_err=0; force-corrupt the stored parity bit and read -> parity_err=1.
